// File: rtl/ds_sample_fifo_loader.sv
// -----------------------------------------------------------------------------
// ds_sample_fifo_loader
//
// Multi-channel sample input buffer for the delta-sigma PWM modulators.
// Bytes arrive from the host on data_in, qualified by toggles of the
// asynchronous data_part_in strobe:
//   - data_part_in falling: data_in is the low byte.
//   - data_part_in rising:  data_in is the high byte. The completed 16-bit
//                           word is pushed into the FIFO of channel ch_sel.
// Each channel FIFO hands its head entry to sample_out on every pulse_done
// of that channel.
//
// Handshake: the host side has no back-pressure. A word that finds its FIFO
// full is dropped and flagged in overflow. pulse_done is a single-cycle pop
// request with no ready. A pop that finds the FIFO empty leaves sample_out
// unchanged and is flagged in underrun. Both flags are sticky until
// clear_flags. When a flag is set in the same cycle as clear_flags, the set
// wins.
//
// Optional feature: define DS_FIFO_LOW_WATER_EN to add parameter LOW_WATER
// and a registered low_water flag per channel (level <= LOW_WATER). Without
// the macro, low_water is tied to 0.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   data_in       host data byte (held stable by host around strobe edges)
//   data_part_in  asynchronous host byte strobe, one toggle per byte
//   ch_sel        target channel of the word being completed
//   pulse_done    per-channel pop request
//   clear_flags   clears overflow / underrun
//   sample_out    16 bits per channel, channel c at [16c+15:16c]
//   level         FIFO occupancy per channel, LVL_BITS bits each
//   overflow      sticky push-dropped flag per channel
//   underrun      sticky pop-on-empty flag per channel
//   low_water     per-channel low occupancy flag (see above)
// -----------------------------------------------------------------------------
module ds_sample_fifo_loader #(
    parameter int          NUM_CH       = 2,
    parameter int          DEPTH        = 4,
    parameter int          SYNC_STAGES  = 2,
    parameter logic [15:0] RESET_SAMPLE = 16'h8000,
`ifdef DS_FIFO_LOW_WATER_EN
    parameter int          LOW_WATER    = 1,
`endif
    localparam int         CH_BITS      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int         LVL_BITS     = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   data_in,
    input  logic                         data_part_in,
    input  logic [CH_BITS-1:0]           ch_sel,
    input  logic [NUM_CH-1:0]            pulse_done,
    input  logic                         clear_flags,
    output logic [16*NUM_CH-1:0]         sample_out,
    output logic [LVL_BITS*NUM_CH-1:0]   level,
    output logic [NUM_CH-1:0]            overflow,
    output logic [NUM_CH-1:0]            underrun,
    output logic [NUM_CH-1:0]            low_water
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    // ---------------------------------------------------------------------
    // Strobe synchronizer and edge detect. Reset to all ones so that a
    // strobe parked high during reset produces no edge on release.
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dp_last_q, dp_last_d;
    logic [7:0]             low_byte_q, low_byte_d;
    logic                   dp;
    logic                   dp_rise;
    logic                   dp_fall;
    logic [15:0]            word;

    assign dp      = sync_q[SYNC_STAGES-1];
    assign dp_rise = dp & ~dp_last_q;
    assign dp_fall = ~dp & dp_last_q;
    assign word    = {data_in, low_byte_q};

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], data_part_in};
        dp_last_d  = dp;
        low_byte_d = low_byte_q;
        if (dp_fall) begin
            low_byte_d = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            dp_last_q  <= 1'b1;
            low_byte_q <= 8'h00;
        end else begin
            sync_q     <= sync_d;
            dp_last_q  <= dp_last_d;
            low_byte_q <= low_byte_d;
        end
    end

    // ---------------------------------------------------------------------
    // Per-channel FIFO, output sample register and sticky flags.
    // ---------------------------------------------------------------------
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [15:0]      mem_q [DEPTH];
        logic [PTR_W-1:0] wptr_q, wptr_d;
        logic [PTR_W-1:0] rptr_q, rptr_d;
        logic [15:0]      sample_q, sample_d;
        logic             ovf_q, ovf_d;
        logic             und_q, und_d;
        logic             push_req;
        logic             empty;
        logic             full;
        logic             pop_ok;
        logic             push_ok;

        // A write with ch_sel >= NUM_CH matches no channel and is dropped
        // without raising any flag.
        assign push_req = dp_rise && (ch_sel == CH_BITS'(c));
        assign empty    = (wptr_q == rptr_q);
        // Full: pointers differ only in the wrap bit.
        assign full     = (wptr_q == {~rptr_q[PTR_W-1], rptr_q[PTR_W-2:0]});
        assign pop_ok   = pulse_done[c] && !empty;
        // A pop in the same cycle frees a slot in a full FIFO. There is no
        // bypass: a pushed word is never popped in the cycle it arrives.
        assign push_ok  = push_req && (!full || pop_ok);

        always_comb begin
            wptr_d   = wptr_q;
            rptr_d   = rptr_q;
            sample_d = sample_q;
            ovf_d    = ovf_q & ~clear_flags;
            und_d    = und_q & ~clear_flags;
            if (push_ok) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (push_req && !push_ok) begin
                ovf_d = 1'b1;
            end
            if (pop_ok) begin
                rptr_d   = rptr_q + PTR_W'(1);
                sample_d = mem_q[rptr_q[ADDR_W-1:0]];
            end
            if (pulse_done[c] && empty) begin
                und_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wptr_q   <= '0;
                rptr_q   <= '0;
                sample_q <= RESET_SAMPLE;
                ovf_q    <= 1'b0;
                und_q    <= 1'b0;
            end else begin
                wptr_q   <= wptr_d;
                rptr_q   <= rptr_d;
                sample_q <= sample_d;
                ovf_q    <= ovf_d;
                und_q    <= und_d;
            end
        end

        // Storage needs no reset: entries are only read after being written.
        always_ff @(posedge clk) begin
            if (push_ok) begin
                mem_q[wptr_q[ADDR_W-1:0]] <= word;
            end
        end

        assign sample_out[16*c +: 16]           = sample_q;
        assign level[LVL_BITS*c +: LVL_BITS]    = wptr_q - rptr_q;
        assign overflow[c]                      = ovf_q;
        assign underrun[c]                      = und_q;

`ifdef DS_FIFO_LOW_WATER_EN
        // Computed from next-state pointers so the flag moves on the same
        // edge as level. Held low in reset; 1 after the first clock.
        logic [LVL_BITS-1:0] lvl_d;
        logic                lw_q, lw_d;

        always_comb begin
            lvl_d = wptr_d - rptr_d;
            lw_d  = (lvl_d <= LVL_BITS'(LOW_WATER));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lw_q <= 1'b0;
            end else begin
                lw_q <= lw_d;
            end
        end

        assign low_water[c] = lw_q;
`else
        assign low_water[c] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ds_sample_fifo_loader.sv
// -----------------------------------------------------------------------------
// tb_ds_sample_fifo_loader
//
// Self-checking bench for ds_sample_fifo_loader (NUM_CH=2, DEPTH=4).
// Each word written to the DUT is pushed to that channel's expected queue
// when it is accepted by the model. It is popped and compared against
// sample_out when the bench drives pulse_done. Level, the sticky flags and
// low_water are checked against the model after every operation.
// -----------------------------------------------------------------------------
module tb_ds_sample_fifo_loader;

    localparam int NUM_CH   = 2;
    localparam int DEPTH    = 4;
    localparam int LVL_BITS = 3;

    // ------------------------------------------------------------ clock/reset
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        data_part_in;
    logic [0:0]  ch_sel;
    logic [1:0]  pulse_done;
    logic        clear_flags;
    logic [31:0] sample_out;
    logic [5:0]  level;
    logic [1:0]  overflow;
    logic [1:0]  underrun;
    logic [1:0]  low_water;

    always #5 clk = ~clk;

    ds_sample_fifo_loader #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .data_part_in (data_part_in),
        .ch_sel       (ch_sel),
        .pulse_done   (pulse_done),
        .clear_flags  (clear_flags),
        .sample_out   (sample_out),
        .level        (level),
        .overflow     (overflow),
        .underrun     (underrun),
        .low_water    (low_water)
    );

    // ------------------------------------------------------------ scoreboard
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [15:0] exp_sample [2];
    logic [1:0]  exp_ovf;
    logic [1:0]  exp_und;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int q_size(input int ch);
        if (ch == 0) return exp_q0.size();
        return exp_q1.size();
    endfunction

    task automatic q_push(input int ch, input logic [15:0] w);
        if (ch == 0) exp_q0.push_back(w);
        else         exp_q1.push_back(w);
    endtask

    task automatic q_pop(input int ch, output logic [15:0] w);
        if (ch == 0) w = exp_q0.pop_front();
        else         w = exp_q1.pop_front();
    endtask

    task automatic model_reset();
        exp_q0.delete();
        exp_q1.delete();
        exp_sample[0] = 16'h8000;
        exp_sample[1] = 16'h8000;
        exp_ovf = 2'b00;
        exp_und = 2'b00;
    endtask

    // One clock of the expected behaviour: pops first (a pop frees a slot
    // for a push to a full FIFO), then the optional push, then flags.
    task automatic model_cycle(input logic [1:0] pop_mask, input int push_ch,
                               input logic [15:0] w, input bit clr);
        logic [1:0]  set_o;
        logic [1:0]  set_u;
        logic [15:0] v;
        set_o = 2'b00;
        set_u = 2'b00;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (pop_mask[ch]) begin
                if (q_size(ch) == 0) begin
                    set_u[ch] = 1'b1;
                end else begin
                    q_pop(ch, v);
                    exp_sample[ch] = v;
                end
            end
        end
        if (push_ch >= 0) begin
            if (q_size(push_ch) < DEPTH) q_push(push_ch, w);
            else                         set_o[push_ch] = 1'b1;
        end
        if (clr) begin
            exp_ovf = 2'b00;
            exp_und = 2'b00;
        end
        exp_ovf = exp_ovf | set_o;
        exp_und = exp_und | set_u;
    endtask

    task automatic check_ch(input int ch);
        int   lvl;
        logic exp_lw;
        lvl = q_size(ch);
`ifdef DS_FIFO_LOW_WATER_EN
        exp_lw = rst_n ? (lvl <= 1) : 1'b0;
`else
        exp_lw = 1'b0;
`endif
        check_val($sformatf("sample_out%0d", ch), 32'(sample_out[16*ch +: 16]), 32'(exp_sample[ch]));
        check_val($sformatf("level%0d", ch), 32'(level[LVL_BITS*ch +: LVL_BITS]), 32'(lvl));
        check_val($sformatf("overflow%0d", ch), 32'(overflow[ch]), 32'(exp_ovf[ch]));
        check_val($sformatf("underrun%0d", ch), 32'(underrun[ch]), 32'(exp_und[ch]));
        check_val($sformatf("low_water%0d", ch), 32'(low_water[ch]), 32'(exp_lw));
    endtask

    // ------------------------------------------------------------ drivers
    // Called at a negedge with data_part_in high. The push lands on the
    // 3rd rising edge after data_part_in rises; level must still be old
    // after the 2nd. Optionally pulses pulse_done[ch] in the push cycle.
    task automatic write_word(input int ch, input logic [15:0] w, input bit pop_with);
        logic [1:0] m;
        m = 2'b00;
        data_in      = w[7:0];
        data_part_in = 1'b0;
        repeat (4) @(negedge clk);
        data_in      = w[15:8];
        ch_sel       = ch[0:0];
        data_part_in = 1'b1;
        repeat (2) @(negedge clk);
        check_val($sformatf("pre_push_level%0d", ch),
                  32'(level[LVL_BITS*ch +: LVL_BITS]), 32'(q_size(ch)));
        if (pop_with) m[ch] = 1'b1;
        pulse_done = m;
        @(negedge clk);
        pulse_done = 2'b00;
        model_cycle(m, ch, w, 1'b0);
        check_ch(0);
        check_ch(1);
    endtask

    task automatic pop(input logic [1:0] mask, input bit clr);
        pulse_done  = mask;
        clear_flags = clr;
        @(negedge clk);
        pulse_done  = 2'b00;
        clear_flags = 1'b0;
        model_cycle(mask, -1, 16'h0000, clr);
        check_ch(0);
        check_ch(1);
    endtask

    // ------------------------------------------------------------ watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [1:0] m;
        rst_n        = 1'b0;
        data_in      = 8'h00;
        data_part_in = 1'b1;
        ch_sel       = 1'b0;
        pulse_done   = 2'b00;
        clear_flags  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_ch(0);
        check_ch(1);
        rst_n = 1'b1;

        // Idle after reset: no spurious push from the synchronizer.
        repeat (10) @(negedge clk);
        check_ch(0);
        check_ch(1);

        // Single word and pop.
        write_word(0, 16'h1234, 1'b0);
        pop(2'b01, 1'b0);

        // Overflow on the 5th push, then drain and underrun.
        for (int i = 1; i <= 5; i++) write_word(1, 16'(i), 1'b0);
        for (int i = 0; i < 5; i++) pop(2'b10, 1'b0);
        pop(2'b00, 1'b1);

        // Full FIFO with push coincident with pop: accepted, no overflow.
        for (int i = 0; i < 4; i++) write_word(1, 16'($urandom_range(0, 65535)), 1'b0);
        write_word(1, 16'hBEEF, 1'b1);
        for (int i = 0; i < 4; i++) pop(2'b10, 1'b0);

        // Empty FIFO with push coincident with pop: underrun, no bypass.
        write_word(0, 16'h0F0F, 1'b1);
        pop(2'b00, 1'b1);
        pop(2'b01, 1'b0);

        // Low-water threshold crossing.
        write_word(0, 16'hA001, 1'b0);
        write_word(0, 16'hA002, 1'b0);
        pop(2'b01, 1'b0);
        pop(2'b01, 1'b0);

        // Flag set coincident with clear_flags: set wins. Both channels pop.
        pop(2'b11, 1'b1);
        pop(2'b00, 1'b1);

        // Random mix of writes and pops on both channels.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                m = 2'($urandom_range(1, 3));
                pop(m, 1'b0);
            end else begin
                write_word($urandom_range(0, 1), 16'($urandom_range(0, 65535)),
                           1'($urandom_range(0, 1)));
            end
        end
        pop(2'b00, 1'b1);

        // Reset in the middle of a byte pair with FIFO contents present.
        write_word(0, 16'h7777, 1'b0);
        data_in      = 8'hAA;
        data_part_in = 1'b0;
        repeat (4) @(negedge clk);
        data_in      = 8'h55;
        data_part_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_ch(0);
        check_ch(1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_ch(0);
        check_ch(1);
        write_word(1, 16'hCAFE, 1'b0);
        pop(2'b10, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ds_sample_fifo_loader.md
Name: ds_sample_fifo_loader

Overview:
- Multi-channel sample input buffer for the delta-sigma PWM modulators.
- Assembles 16-bit samples from the 8-bit host bus using the data_part toggle protocol, and routes each sample to a per-channel FIFO.
- Each FIFO releases one sample to its modulator's input register every time that channel's modulator finishes a pulse (pulse_done).
- Sits between the top-level pad decode and the delta_sigma_pw_modulator instances, and replaces the single static sample register.

Parameters:
- NUM_CH, 2, number of modulator channels (1..8)
- DEPTH, 4, FIFO entries per channel; power of two, 2..16
- SYNC_STAGES, 2, synchronizer flops on data_part_in (>=2)
- RESET_SAMPLE, 16'h8000, value held by each sample_out after reset (mid-scale)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  8  host data byte; unsynchronized, host holds it stable around data_part edges
- data_part_in  in  1  host byte strobe; asynchronous, toggles once per byte
- ch_sel  in  CH_BITS=max(1,$clog2(NUM_CH))  target channel for the word being completed
- pulse_done  in  NUM_CH  per-channel single-cycle pop request from the modulator
- clear_flags  in  1  synchronous pulse; clears all sticky flags
- sample_out  out  16*NUM_CH  current sample per channel; channel c occupies [16c+15:16c]
- level  out  LVL_BITS*NUM_CH  FIFO occupancy per channel; LVL_BITS=$clog2(DEPTH)+1
- overflow  out  NUM_CH  sticky: push dropped because the FIFO was full
- underrun  out  NUM_CH  sticky: pulse_done arrived with the FIFO empty
- low_water  out  NUM_CH  see Optional Feature

Behaviour:
- Reset (async, rst_n=0):
  - Synchronizer chain is all ones (no spurious edge on release).
  - low byte register = 0.
  - All FIFO pointers = 0, so level = 0.
  - sample_out = RESET_SAMPLE on every channel.
  - overflow, underrun and low_water = 0.
- Sync and edge detect:
  - data_part_in shifts through SYNC_STAGES flops plus one history flop.
  - Let dp be the synchronized value and dp_last the history value.
- Low byte: on a cycle where dp=0 and dp_last=1, the low byte register captures data_in.
- Word write:
  - On a cycle where dp=1 and dp_last=0, word = {data_in, low byte}. The push targets channel ch_sel, sampled in that same cycle.
  - With SYNC_STAGES=2, the push lands on the 3rd rising clk edge after data_part_in rises; level updates on that edge.
  - If ch_sel >= NUM_CH, the write is discarded and no flag is set.
- Push to channel c:
  - Not full: write at the write pointer, increment the pointer, level +1.
  - Full: discard the word and set overflow[c]. Exception: a pop on channel c in the same cycle frees a slot, so the push is accepted and no flag is set.
- Pop on pulse_done[c]:
  - Not empty: sample_out[c] loads the head entry on the same edge; read pointer increments, level -1.
  - Empty: sample_out[c] holds its value and underrun[c] is set.
  - No bypass: if empty with push and pop in the same cycle, underrun is set, the push lands, and level = 1.
- Simultaneous push and pop on the same channel with the FIFO neither empty nor full: level is unchanged.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full means the pointers differ only in the MSB.
- Channels are fully independent; any number of pulse_done bits may be high in one cycle.
- clear_flags clears all sticky flags. If a flag-setting event coincides with clear_flags, the set wins.
- Reset mid-operation: an incomplete byte pair is lost. The FIFO contents are discarded and sample_out returns to RESET_SAMPLE.

Optional Feature:
- Macro: DS_FIFO_LOW_WATER_EN.
- When defined:
  - Adds parameter LOW_WATER (default 1).
  - low_water[c] is a registered output: high when level[c] <= LOW_WATER, updated on the same edge as level.
  - Reset value 1 after its first clock; held at 0 while rst_n is low.
- When not defined: low_water is tied to 0 and the comparison logic is absent.

Test Plan:
- Reset then idle 10 cycles -> sample_out = 16'h8000 on both channels, level = 0, all flags 0, no push despite the synchronizer being released.
- Bytes 8'h34 (dp low) then 8'h12 (dp high), ch_sel=0; then pulse_done[0] -> level0 = 1 on the 3rd edge after the dp rise, then sample_out[15:0] = 16'h1234 on the pop edge, level0 = 0.
- Push 5 words (1..5) to ch1 with DEPTH=4 -> level1 = 4, overflow[1] = 1; four pops give 1,2,3,4; a fifth pop leaves sample_out at 4 and sets underrun[1] = 1.
- FIFO full, push coincident with pulse_done -> push accepted, level stays 4, overflow stays 0; pops return the old head first and the new word last.
- Empty ch0, push coincident with pulse_done[0] -> underrun[0] = 1, level0 = 1, sample_out unchanged; clear_flags -> underrun[0] = 0.
- With DS_FIFO_LOW_WATER_EN and LOW_WATER=1: push 2 words -> low_water = 0; pop once -> low_water = 1.
